// File: rtl/cnn_tile_sequencer.sv
// Batch sequencer for CNN_Core: issues the start pulse, streams each tile from the
// synchronous-read tile buffer without gaps, then waits for and forwards the tile's results.
module cnn_tile_sequencer #(
    parameter int IMAGE_WIDTH  = 16,
    parameter int MAX_TILES    = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int OUT_PER_TILE = 196,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iGo,
    input  logic [4:0]            iNumTiles,
    input  logic                  iAbort,
    output logic                  oRdEn,
    output logic [ADDR_WIDTH-1:0] oRdAddr,
    input  logic [7:0]            iRdData,
    output logic                  oCoreStart,
    output logic [7:0]            oCoreData,
    output logic                  oCoreValid,
    input  logic [7:0]            iCoreResult,
    input  logic                  iCoreValid,
    output logic [7:0]            oResult,
    output logic                  oValid,
    output logic [3:0]            oTileIdx,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oTimeout
);
    localparam int P      = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int PIX_W  = $clog2(P);
    localparam int RES_W  = $clog2(OUT_PER_TILE + 1);
    localparam int WAIT_W = $clog2(FLUSH_CYCLES);
    localparam int CNT_W  = $clog2(MAX_TILES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STREAM, S_FLUSH, S_NEXT, S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   tile_cnt;
    logic [CNT_W-1:0]   num_clamped;
    logic [3:0]         tile_idx;
    logic [PIX_W-1:0]   pix_cnt;
    logic [RES_W-1:0]   res_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               last_pix, res_done, wait_expired, last_tile;

    assign last_pix     = (pix_cnt == PIX_W'(P - 1));
    assign res_done     = (res_cnt >= RES_W'(OUT_PER_TILE));
    assign wait_expired = (wait_cnt == WAIT_W'(FLUSH_CYCLES - 1));
    assign last_tile    = ((CNT_W'(tile_idx) + CNT_W'(1)) == tile_cnt);

    // The core only sees data while a read is in flight; otherwise the bus stays quiet.
    assign oCoreData = oCoreValid ? iRdData : 8'd0;

    always_comb begin
        num_clamped = CNT_W'(iNumTiles);
        if (iNumTiles == 5'd0)
            num_clamped = CNT_W'(1);
        else if (int'(iNumTiles) > MAX_TILES)
            num_clamped = CNT_W'(MAX_TILES);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        oRdEn      = 1'b0;
        oCoreStart = 1'b0;
        oBusy      = 1'b1;
        oDone      = 1'b0;
        case (state)
            S_IDLE: begin
                oBusy = 1'b0;
                if (iGo) state_nx = S_START;
            end
            S_START: begin
                oCoreStart = 1'b1;
                state_nx   = S_STREAM;
            end
            S_STREAM: begin
                oRdEn = 1'b1;
                if (last_pix) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (res_done || wait_expired) state_nx = S_NEXT;
            end
            S_NEXT: begin
                state_nx = last_tile ? S_DONE : S_START;
            end
            S_DONE: begin
                oDone    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous go in IDLE.
        if (iAbort) state_nx = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= S_IDLE;
            tile_cnt   <= '0;
            tile_idx   <= '0;
            pix_cnt    <= '0;
            res_cnt    <= '0;
            wait_cnt   <= '0;
            oRdAddr    <= '0;
            oCoreValid <= 1'b0;
            oResult    <= 8'd0;
            oValid     <= 1'b0;
            oTileIdx   <= 4'd0;
            oTimeout   <= 1'b0;
        end else begin
            state      <= state_nx;
            oResult    <= iCoreResult;
            oValid     <= iCoreValid;
            oTileIdx   <= tile_idx;
            // Squash the read still in flight when aborting.
            oCoreValid <= oRdEn && !iAbort;

            case (state)
                S_IDLE: begin
                    if (state_nx == S_START) begin
                        tile_cnt <= num_clamped;
                        tile_idx <= '0;
                        oTimeout <= 1'b0;
                    end
                end
                S_START: begin
                    oRdAddr <= ADDR_WIDTH'(tile_idx * P);
                    pix_cnt <= '0;
                end
                S_STREAM: begin
                    oRdAddr <= oRdAddr + ADDR_WIDTH'(1);
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
                S_FLUSH: begin
                    if (state_nx == S_NEXT && !res_done) oTimeout <= 1'b1;
                end
                S_NEXT: begin
                    if (state_nx == S_START) tile_idx <= tile_idx + 4'd1;
                end
                default: ;
            endcase

            wait_cnt <= (state == S_FLUSH) ? wait_cnt + WAIT_W'(1) : '0;

            // Results that arrive on the FLUSH exit cycle are surplus; later ones belong to the next tile.
            if (state == S_IDLE || (state == S_FLUSH && state_nx != S_FLUSH))
                res_cnt <= '0;
            else if (state != S_DONE && iCoreValid && !res_done)
                res_cnt <= res_cnt + RES_W'(1);
        end
    end
endmodule

// File: tb/tb_cnn_tile_sequencer.sv
// Directed bench for cnn_tile_sequencer with a synchronous-read buffer model and a
// simple core model that emits a configurable number of results per tile.
module tb_cnn_tile_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        go, abort;
    logic [4:0]  num_tiles;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        core_start;
    logic [7:0]  core_data;
    logic        core_valid;
    logic [7:0]  core_r;
    logic        core_v;
    logic [7:0]  result;
    logic        valid;
    logic [3:0]  tile_idx;
    logic        busy, done, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cnn_tile_sequencer dut (
        .iClk(clk), .iRst(rst), .iGo(go), .iNumTiles(num_tiles), .iAbort(abort),
        .oRdEn(rd_en), .oRdAddr(rd_addr), .iRdData(rd_data),
        .oCoreStart(core_start), .oCoreData(core_data), .oCoreValid(core_valid),
        .iCoreResult(core_r), .iCoreValid(core_v),
        .oResult(result), .oValid(valid), .oTileIdx(tile_idx),
        .oBusy(busy), .oDone(done), .oTimeout(timeout)
    );

    function automatic logic [7:0] pix(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    // Tile buffer: synchronous read.
    always @(posedge clk) if (rd_en) rd_data <= pix(rd_addr);

    // Core model: after 60 input beats, emits one result per beat up to core_limit.
    int core_limit = 196;
    int beat, emitted;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= 0; emitted <= 0; core_v <= 1'b0; core_r <= 8'd0;
        end else if (core_start) begin
            beat <= 0; emitted <= 0; core_v <= 1'b0;
        end else begin
            core_v <= 1'b0;
            if (core_valid) begin
                beat <= beat + 1;
                if (beat >= 60 && emitted < core_limit) begin
                    core_v  <= 1'b1;
                    core_r  <= 8'(emitted) ^ 8'hA5;
                    emitted <= emitted + 1;
                end
            end
        end
    end

    // Per-batch observations gathered by run_batch.
    int st_start_cnt, st_first_start, st_first_rd, st_first_cv;
    int st_rd_cnt, st_addr_err, st_cv_cnt, st_cv_err, st_data_err, st_gap_err;
    int st_res_err, st_order_err, st_done_cnt, st_done_cyc, st_timeout_first;
    int st_vt[16];
    logic st_timeout_c1, st_busy_after;

    task automatic run_batch(input logic [4:0] nt, input int budget, input bit go_noise);
        int exp_addr, last_idx;
        logic prev_rd, prev_start, prev2_rd, prev2_start;
        logic [11:0] addr_q[$];
        st_start_cnt = 0; st_first_start = 0; st_first_rd = 0; st_first_cv = 0;
        st_rd_cnt = 0; st_addr_err = 0; st_cv_cnt = 0; st_cv_err = 0; st_data_err = 0;
        st_gap_err = 0; st_res_err = 0; st_order_err = 0; st_done_cnt = 0; st_done_cyc = 0;
        st_timeout_first = 0; st_timeout_c1 = 1'b1; st_busy_after = 1'b1;
        for (int i = 0; i < 16; i++) st_vt[i] = 0;
        exp_addr = 0; last_idx = 0;
        prev_rd = 0; prev_start = 0; prev2_rd = 0; prev2_start = 0;
        @(negedge clk);
        num_tiles = nt; go = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            go = go_noise && (c == 100 || c == 150);
            if (go_noise) num_tiles = 5'd5;
            if (c == 1) st_timeout_c1 = timeout;
            if (core_start) begin
                st_start_cnt++;
                if (st_first_start == 0) st_first_start = c;
            end
            if (rd_en) begin
                if (st_first_rd == 0) st_first_rd = c;
                if (rd_addr !== 12'(exp_addr)) st_addr_err++;
                if (!prev_rd && !(prev_start && !prev2_rd && !prev2_start)) st_gap_err++;
                exp_addr++;
                st_rd_cnt++;
                addr_q.push_back(rd_addr);
            end
            if (core_valid !== prev_rd) st_cv_err++;
            if (core_valid) begin
                st_cv_cnt++;
                if (st_first_cv == 0) st_first_cv = c;
                if (addr_q.size() == 0) st_data_err++;
                else if (core_data !== pix(addr_q.pop_front())) st_data_err++;
            end
            if (valid) begin
                if (int'(tile_idx) < last_idx) st_order_err++;
                if (result !== (8'(st_vt[tile_idx]) ^ 8'hA5)) st_res_err++;
                st_vt[tile_idx]++;
                last_idx = int'(tile_idx);
            end
            if (timeout && st_timeout_first == 0) st_timeout_first = c;
            if (st_done_cnt > 0 && c == st_done_cyc + 1) st_busy_after = busy;
            if (done) begin
                st_done_cnt++;
                st_done_cyc = c;
            end
            prev2_rd = prev_rd; prev2_start = prev_start;
            prev_rd = rd_en; prev_start = core_start;
            if (st_done_cnt > 0 && c >= st_done_cyc + 3) break;
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0; num_tiles = 5'd1;
        repeat (3) @(negedge clk);
        n_tests++; if ({rd_en, core_start, core_valid, valid, busy, done, timeout} !== 7'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000000", {rd_en, core_start, core_valid, valid, busy, done, timeout}); end
        n_tests++; if ({rd_addr, core_data, result, tile_idx} !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0", {rd_addr, core_data, result, tile_idx}); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_tile();
        core_limit = 196;
        run_batch(5'd1, 300, 1'b0);
        n_tests++; if (st_first_start != 1) begin n_fail++; $display("FAIL single_start_cycle: got %0d required 1", st_first_start); end
        n_tests++; if (st_first_rd != 2) begin n_fail++; $display("FAIL single_rd_cycle: got %0d required 2", st_first_rd); end
        n_tests++; if (st_first_cv != 3) begin n_fail++; $display("FAIL single_cv_cycle: got %0d required 3", st_first_cv); end
        n_tests++; if (st_rd_cnt != 256 || st_addr_err != 0) begin n_fail++; $display("FAIL single_addr: reads %0d errs %0d required 256/0", st_rd_cnt, st_addr_err); end
        n_tests++; if (st_cv_cnt != 256 || st_cv_err != 0 || st_data_err != 0) begin n_fail++; $display("FAIL single_stream: beats %0d cv_err %0d data_err %0d required 256/0/0", st_cv_cnt, st_cv_err, st_data_err); end
        n_tests++; if (st_vt[0] != 196 || st_res_err != 0) begin n_fail++; $display("FAIL single_results: got %0d errs %0d required 196/0", st_vt[0], st_res_err); end
        n_tests++; if (st_done_cnt != 1 || st_done_cyc != 262) begin n_fail++; $display("FAIL single_done: count %0d cycle %0d required 1/262", st_done_cnt, st_done_cyc); end
        n_tests++; if (st_timeout_first != 0 || timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: first %0d now %b required 0/0", st_timeout_first, timeout); end
        n_tests++; if (st_busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_done: got %b required 0", st_busy_after); end
    endtask

    task automatic test_three_tiles();
        core_limit = 196;
        run_batch(5'd3, 820, 1'b0);
        n_tests++; if (st_rd_cnt != 768 || st_addr_err != 0) begin n_fail++; $display("FAIL three_addr: reads %0d errs %0d required 768/0", st_rd_cnt, st_addr_err); end
        n_tests++; if (st_start_cnt != 3) begin n_fail++; $display("FAIL three_starts: got %0d required 3", st_start_cnt); end
        n_tests++; if (st_vt[0] != 196 || st_vt[1] != 196 || st_vt[2] != 196 || st_vt[3] != 0) begin n_fail++; $display("FAIL three_tile_counts: got %0d %0d %0d %0d required 196 196 196 0", st_vt[0], st_vt[1], st_vt[2], st_vt[3]); end
        n_tests++; if (st_order_err != 0 || st_res_err != 0) begin n_fail++; $display("FAIL three_order: order %0d res %0d required 0/0", st_order_err, st_res_err); end
        n_tests++; if (st_gap_err != 0 || st_cv_err != 0) begin n_fail++; $display("FAIL three_gap: gap %0d cv %0d required 0/0", st_gap_err, st_cv_err); end
        n_tests++; if (st_done_cyc != 784) begin n_fail++; $display("FAIL three_done_cycle: got %0d required 784", st_done_cyc); end
    endtask

    task automatic test_timeout();
        core_limit = 100;
        run_batch(5'd2, 700, 1'b0);
        n_tests++; if (st_timeout_c1 !== 1'b0) begin n_fail++; $display("FAIL timeout_initial: got %b required 0", st_timeout_c1); end
        n_tests++; if (st_timeout_first != 322) begin n_fail++; $display("FAIL timeout_set_cycle: got %0d required 322", st_timeout_first); end
        n_tests++; if (st_done_cyc != 645 || st_start_cnt != 2) begin n_fail++; $display("FAIL timeout_continue: done %0d starts %0d required 645/2", st_done_cyc, st_start_cnt); end
        n_tests++; if (st_vt[0] != 100 || st_vt[1] != 100) begin n_fail++; $display("FAIL timeout_results: got %0d %0d required 100 100", st_vt[0], st_vt[1]); end
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b required 1", timeout); end
        core_limit = 196;
        run_batch(5'd1, 300, 1'b0);
        n_tests++; if (st_timeout_c1 !== 1'b0 || st_timeout_first != 0) begin n_fail++; $display("FAIL timeout_cleared: c1 %b first %0d required 0/0", st_timeout_c1, st_timeout_first); end
    endtask

    task automatic test_abort();
        bit hit;
        int dones, reads;
        core_limit = 196;
        hit = 0;
        @(negedge clk);
        num_tiles = 5'd3; go = 1'b1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (rd_en && rd_addr == 12'd293) begin hit = 1; break; end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL abort_reach_pixel: got 0 required 1"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++; if ({rd_en, core_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL abort_drop: rd/cv/busy %b required 000", {rd_en, core_valid, busy}); end
        dones = 0; reads = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) dones++;
            if (rd_en || core_start) reads++;
        end
        n_tests++; if (dones != 0 || reads != 0) begin n_fail++; $display("FAIL abort_quiet: dones %0d activity %0d required 0/0", dones, reads); end
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        n_tests++; if (busy !== 1'b0 || core_start !== 1'b0) begin n_fail++; $display("FAIL abort_beats_go: busy %b start %b required 0/0", busy, core_start); end
    endtask

    task automatic test_go_and_clamp();
        core_limit = 196;
        run_batch(5'd0, 300, 1'b1);
        n_tests++; if (st_start_cnt != 1 || st_done_cyc != 262) begin n_fail++; $display("FAIL clamp_zero: starts %0d done %0d required 1/262", st_start_cnt, st_done_cyc); end
        run_batch(5'd31, 4200, 1'b0);
        n_tests++; if (st_start_cnt != 16 || st_done_cyc != 4177) begin n_fail++; $display("FAIL clamp_max: starts %0d done %0d required 16/4177", st_start_cnt, st_done_cyc); end
        n_tests++; if (st_rd_cnt != 4096 || st_addr_err != 0 || st_vt[15] != 196) begin n_fail++; $display("FAIL clamp_max_stream: reads %0d errs %0d last %0d required 4096/0/196", st_rd_cnt, st_addr_err, st_vt[15]); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        num_tiles = 5'd2; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (50) @(negedge clk);
        n_tests++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL areset_mid_stream: rd_en %b required 1", rd_en); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({rd_en, core_start, core_valid, valid, busy, done, timeout} !== 7'd0 ||
                       {rd_addr, core_data, result, tile_idx} !== 32'd0) begin
            n_fail++; $display("FAIL areset_outputs: ctrl %b data %h required 0/0", {rd_en, core_start, core_valid, valid, busy, done, timeout}, {rd_addr, core_data, result, tile_idx}); end
        @(negedge clk);
        rst = 1'b0;
        run_batch(5'd1, 300, 1'b0);
        n_tests++; if (st_done_cyc != 262 || st_addr_err != 0 || st_vt[0] != 196) begin n_fail++; $display("FAIL areset_recover: done %0d addr_err %0d res %0d required 262/0/196", st_done_cyc, st_addr_err, st_vt[0]); end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_timeout();
        test_abort();
        test_go_and_clamp();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
